pio_write_arbiter: RTL

// - Round-robin arbiter/sequencer sharing one 8-bit Avalon-MM output PIO (s1 slave) among NUM_REQ requesters.
// - Typical requesters in the parking controller: barrier FSM, occupancy display, alarm logic.
// - Sits between those hardware requesters and the PIO slave port; serialises their writes to PIO address 0.
// - Optionally reads the register back after each write to confirm the update.

---
 rtl/pio_write_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/pio_write_arbiter.sv
// Round-robin write sequencer that shares one 8-bit Avalon-MM output PIO
// (s1 slave, address 0) among NUM_REQ hardware requesters.
// Optional build macro PIO_WR_READBACK_EN: each write is followed by a
// one-cycle read of the PIO register. The read value is compared against the
// written data, and a mismatch sets the sticky err_mismatch flag.
module pio_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      busy,
    output logic                      pio_chipselect,
    output logic                      pio_write_n,
    output logic [1:0]                pio_address,
    output logic [31:0]               pio_writedata,
    input  logic [31:0]               pio_readdata,
    input  logic                      err_clr,
    output logic                      err_mismatch
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [3:0] GAP_LOAD = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;
    localparam logic [1:0] ST_GAP   = 2'd3;

    // Index that lies 'off' positions above 'base', wrapping at NUM_REQ.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end else begin
            s = s;
        end
        return IDX_W'(s);
    endfunction

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_owner;
    logic [DATA_W-1:0] r_data;
    logic [3:0]        r_gap_cnt;
    logic [NUM_REQ-1:0] r_gnt;
    logic              r_busy;
    logic              r_cs;
    logic              r_wr_n;
    logic [31:0]       r_wdata;
    logic              r_err;

    logic              w_found;
    logic [IDX_W-1:0]  w_pick;
    logic [DATA_W-1:0] w_pick_data;
    logic [1:0]        w_next;
    logic [1:0]        w_after_rw;
    logic [1:0]        w_after_write;
    logic              w_unused;

    // Search upward from the pointer for the first pending requester.
    always_comb begin
        w_found = 1'b0;
        w_pick  = {IDX_W{1'b0}};
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!w_found && req[rr_index(r_ptr, i)]) begin
                w_found = 1'b1;
                w_pick  = rr_index(r_ptr, i);
            end else begin
                w_found = w_found;
            end
        end
        w_pick_data = req_data[int'(w_pick)*DATA_W +: DATA_W];
    end

    // Successor states of WRITE and READ, fixed by the build configuration.
    always_comb begin
        if (GAP_CYCLES == 0) begin
            w_after_rw = ST_IDLE;
        end else begin
            w_after_rw = ST_GAP;
        end
`ifdef PIO_WR_READBACK_EN
        w_after_write = ST_READ;
`else
        w_after_write = w_after_rw;
`endif
    end

    // Next-state logic of the sequencing FSM.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next = ST_WRITE;
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_WRITE: w_next = w_after_write;
            ST_READ:  w_next = w_after_rw;
            ST_GAP: begin
                if (r_gap_cnt == 4'd0) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_GAP;
                end
            end
            default:  w_next = ST_IDLE;
        endcase
    end

    // State, arbitration bookkeeping and registered bus outputs derived from the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= {IDX_W{1'b0}};
            r_owner   <= {IDX_W{1'b0}};
            r_data    <= {DATA_W{1'b0}};
            r_gap_cnt <= 4'd0;
            r_gnt     <= {NUM_REQ{1'b0}};
            r_busy    <= 1'b0;
            r_cs      <= 1'b0;
            r_wr_n    <= 1'b1;
            r_wdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != ST_IDLE);
            r_cs    <= (w_next == ST_WRITE) || (w_next == ST_READ);
            r_wr_n  <= (w_next != ST_WRITE);
            if (r_state == ST_IDLE && w_found) begin
                r_owner <= w_pick;
                r_data  <= w_pick_data;
                r_wdata <= {{(32-DATA_W){1'b0}}, w_pick_data};
                r_gnt   <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
            end else begin
                r_gnt   <= {NUM_REQ{1'b0}};
            end
            if (r_state == ST_WRITE) begin
                r_ptr <= rr_index(r_owner, 1);
            end else begin
                r_ptr <= r_ptr;
            end
            if (w_next == ST_GAP && r_state != ST_GAP) begin
                r_gap_cnt <= GAP_LOAD;
            end else if (r_state == ST_GAP && r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end else begin
                r_gap_cnt <= r_gap_cnt;
            end
        end
    end

`ifdef PIO_WR_READBACK_EN
    // Sticky readback-mismatch flag; a new mismatch takes priority over a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else if (r_state == ST_READ && pio_readdata[DATA_W-1:0] != r_data) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end else begin
            r_err <= r_err;
        end
    end
    assign w_unused = ^pio_readdata;
`else
    // Without readback the mismatch flag is permanently clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= 1'b0;
        end
    end
    assign w_unused = ^{pio_readdata, err_clr};
`endif

    assign gnt            = r_gnt;
    assign busy           = r_busy;
    assign pio_chipselect = r_cs;
    assign pio_write_n    = r_wr_n;
    assign pio_address    = 2'd0;
    assign pio_writedata  = r_wdata;
    assign err_mismatch   = r_err;

endmodule
